// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if: request/response bundle between the Execute-stage pipeline
// (master) and the iterative multiply/divide unit (slave).
interface muldiv_iter_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, result_valid, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, result_valid, result_hi, result_lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative MULT/MULTU/DIV/DIVU unit for the HI/LO path.
// Operands are folded to unsigned magnitudes in PREP, one result bit is
// produced per CALC cycle (shift-add or restoring divide sharing the hi/lo
// working pair), and signs are re-applied as the result registers load on
// the transition into DONE, so the values are final while result_valid is up.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's-complement negation of a single word.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a double-width product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] b_raw_q, b_raw_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;           // partial product high / remainder
  logic [WIDTH-1:0] lo_q, lo_d;           // multiplier bits / dividend->quotient
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             res_dbz_q, res_dbz_d;

  logic             accept_s;
  logic             finish_s;
  logic             is_mul_s;
  logic             is_signed_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] div_sub_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] hi_step_s;
  logic [WIDTH-1:0] lo_step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] fin_hi_s;
  logic [WIDTH-1:0] fin_lo_s;

  assign is_mul_s    = ~op_q[1];
  assign is_signed_s = ~op_q[0];
  assign accept_s    = (state_q == ST_IDLE) && bus.start && !bus.cancel;
  assign finish_s    = (state_q == ST_CALC) && !bus.cancel && (cnt_q == CW'(1));

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.result_hi    = res_hi_q;
  assign bus.result_lo    = res_lo_q;
  assign bus.div_by_zero  = res_dbz_q;

  // Next-state decode; cancel returns to IDLE from any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fold the sampled operands to magnitudes; unsigned ops never negate.
  always_comb begin
    sign_a_s = is_signed_s & a_raw_q[WIDTH-1];
    sign_b_s = is_signed_s & b_raw_q[WIDTH-1];
    if (sign_a_s) begin
      mag_a_s = neg_w(a_raw_q);
    end else begin
      mag_a_s = a_raw_q;
    end
    if (sign_b_s) begin
      mag_b_s = neg_w(b_raw_q);
    end else begin
      mag_b_s = b_raw_q;
    end
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + {1'b0, mcand_q};
    div_shift_s = {hi_q, lo_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, mcand_q});
    div_sub_s   = div_shift_s[WIDTH-1:0] - mcand_q;
    if (is_mul_s) begin
      if (lo_q[0]) begin
        hi_step_s = mul_sum_s[WIDTH:1];
        lo_step_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_step_s = {1'b0, hi_q[WIDTH-1:1]};
        lo_step_s = {hi_q[0], lo_q[WIDTH-1:1]};
      end
    end else begin
      if (div_ge_s) begin
        hi_step_s = div_sub_s;
      end else begin
        hi_step_s = div_shift_s[WIDTH-1:0];
      end
      lo_step_s = {lo_q[WIDTH-2:0], div_ge_s};
    end
  end

  // Final result from the last iteration with signs re-applied.
  always_comb begin
    prod_s = {hi_step_s, lo_step_s};
    if (neg_res_q) begin
      prod_s = neg_2w({hi_step_s, lo_step_s});
    end else begin
      prod_s = {hi_step_s, lo_step_s};
    end
    if (is_mul_s) begin
      fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_s[WIDTH-1:0];
    end else if (dbz_q) begin
      fin_hi_s = a_raw_q;
      fin_lo_s = {WIDTH{1'b1}};
    end else begin
      if (neg_res_q) begin
        fin_lo_s = neg_w(lo_step_s);
      end else begin
        fin_lo_s = lo_step_s;
      end
      if (neg_rem_q) begin
        fin_hi_s = neg_w(hi_step_s);
      end else begin
        fin_hi_s = hi_step_s;
      end
    end
  end

  // Working-register next values: sample in IDLE, prepare in PREP, iterate in CALC.
  always_comb begin
    op_d      = op_q;
    a_raw_d   = a_raw_q;
    b_raw_d   = b_raw_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d    = bus.op;
          a_raw_d = bus.src_a;
          b_raw_d = bus.src_b;
        end else begin
          op_d    = op_q;
        end
      end
      ST_PREP: begin
        hi_d      = {WIDTH{1'b0}};
        cnt_d     = CW'(WIDTH);
        neg_res_d = sign_a_s ^ sign_b_s;
        if (is_mul_s) begin
          mcand_d   = mag_a_s;
          lo_d      = mag_b_s;
          neg_rem_d = 1'b0;
          dbz_d     = 1'b0;
        end else begin
          mcand_d   = mag_b_s;
          lo_d      = mag_a_s;
          neg_rem_d = sign_a_s;
          dbz_d     = (b_raw_q == {WIDTH{1'b0}});
        end
      end
      ST_CALC: begin
        hi_d  = hi_step_s;
        lo_d  = lo_step_s;
        cnt_d = cnt_q - CW'(1);
      end
      ST_DONE: begin
        cnt_d = {CW{1'b0}};
      end
      default: begin
        cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // Result registers hold until the next completed operation.
  always_comb begin
    if (finish_s) begin
      res_hi_d  = fin_hi_s;
      res_lo_d  = fin_lo_s;
      res_dbz_d = dbz_q;
    end else begin
      res_hi_d  = res_hi_q;
      res_lo_d  = res_lo_q;
      res_dbz_d = res_dbz_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working registers for operands, counter and iteration state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= 2'b00;
      a_raw_q   <= {WIDTH{1'b0}};
      b_raw_q   <= {WIDTH{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_raw_q   <= a_raw_d;
      b_raw_q   <= b_raw_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  // Architectural result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_hi_q  <= {WIDTH{1'b0}};
      res_lo_q  <= {WIDTH{1'b0}};
      res_dbz_q <= 1'b0;
    end else begin
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      res_dbz_q <= res_dbz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vectors for muldiv_iter with an arithmetic
// reference model and a per-cycle compare of all outputs.
module tb_muldiv_iter;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(W)) bus ();

  muldiv_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: cycles remaining until the unit is idle again, the pending
  // result of the operation in flight, and the result currently held.
  int         rem_cyc  = 0;
  logic [W-1:0] pend_hi  = '0;
  logic [W-1:0] pend_lo  = '0;
  logic         pend_dbz = 1'b0;
  logic [W-1:0] hold_hi  = '0;
  logic [W-1:0] hold_lo  = '0;
  logic         hold_dbz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for all four operations.
  task automatic model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sb  = $signed(b);
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          dbz = 1'b1; hi = a; lo = '1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endtask

  // Model advance on each rising edge, using the inputs the DUT samples.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_cyc  = 0;
      hold_hi  = '0;
      hold_lo  = '0;
      hold_dbz = 1'b0;
    end else if (rem_cyc == 0) begin
      if (bus.start && !bus.cancel) begin
        rem_cyc = LAT;
        model_op(bus.op, bus.src_a, bus.src_b, pend_hi, pend_lo, pend_dbz);
      end
    end else if (bus.cancel) begin
      rem_cyc = 0;
    end else begin
      rem_cyc = rem_cyc - 1;
      if (rem_cyc == 1) begin
        hold_hi  = pend_hi;
        hold_lo  = pend_lo;
        hold_dbz = pend_dbz;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("cyc_busy",  64'(bus.busy),         64'(rem_cyc > 0));
      chk("cyc_valid", 64'(bus.result_valid), 64'(rem_cyc == 1));
      chk("cyc_hi",    64'(bus.result_hi),    64'(hold_hi));
      chk("cyc_lo",    64'(bus.result_lo),    64'(hold_lo));
      chk("cyc_dbz",   64'(bus.div_by_zero),  64'(hold_dbz));
    end
  end

  // One operation with literal expectations; poke>0 pulses a stray start
  // with other operands that many cycles after the accept.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edbz, input int poke);
    logic [W-1:0] mhi, mlo;
    logic         mdbz;
    int           lat, busy_n;
    model_op(op, a, b, mhi, mlo, mdbz);
    chk({name, "/model_hi"},  64'(mhi),  64'(ehi));
    chk({name, "/model_lo"},  64'(mlo),  64'(elo));
    chk({name, "/model_dbz"}, 64'(mdbz), 64'(edbz));
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    lat = 0; busy_n = 0;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.src_a = ~a; bus.src_b = ~b; bus.op = ~op;
      if (poke > 0 && k == poke) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd5; bus.src_b = 32'd5;
      end
      if (bus.busy) busy_n++;
      if (bus.result_valid) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    chk({name, "/latency"}, 64'(lat),    64'(LAT));
    chk({name, "/busy_n"},  64'(busy_n), 64'(LAT));
    chk({name, "/hi"},  64'(bus.result_hi),   64'(ehi));
    chk({name, "/lo"},  64'(bus.result_lo),   64'(elo));
    chk({name, "/dbz"}, 64'(bus.div_by_zero), 64'(edbz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst/busy",  64'(bus.busy),         64'd0);
    chk("rst/valid", 64'(bus.result_valid), 64'd0);
    chk("rst/hi",    64'(bus.result_hi),    64'd0);
    chk("rst/lo",    64'(bus.result_lo),    64'd0);
    chk("rst/dbz",   64'(bus.div_by_zero),  64'd0);

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
    run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0);
    run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);
    run_op("div_negb",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
    run_op("div_zero",  2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 0);
    run_op("divu_zero", 2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 0);
    run_op("divu_7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0);

    // Cancel after 10 CALC cycles: no result, previous result kept.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd7; bus.src_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel/busy", 64'(bus.busy),      64'd0);
    chk("cancel/hi",   64'(bus.result_hi), 64'd2);
    chk("cancel/lo",   64'(bus.result_lo), 64'd14);
    seen = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (bus.result_valid) seen++;
    end
    chk("cancel/no_valid", 64'(seen), 64'd0);

    // start together with cancel in IDLE is not accepted.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("idle_cancel/busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("idle_cancel/busy2", 64'(bus.busy), 64'd0);

    // A stray start while busy is ignored.
    run_op("busy_start", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 6);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst/busy",  64'(bus.busy),         64'd0);
    chk("arst/valid", 64'(bus.result_valid), 64'd0);
    chk("arst/hi",    64'(bus.result_hi),    64'd0);
    chk("arst/lo",    64'(bus.result_lo),    64'd0);
    chk("arst/dbz",   64'(bus.div_by_zero),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst/idle", 64'(bus.busy), 64'd0);

    run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0);
    run_op("b2b_multu", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
